stream_demux_serializer: RTL and testbench

STREAM_DEMUX_SERIALIZER -- requirements
Module: stream_demux_serializer

---
 rtl/stream_demux_serializer_pkg.sv | 26 ++
 rtl/stream_demux_serializer_if.sv | 52 +++++
 rtl/stream_demux_serializer_axis_reg_slice.sv | 59 +++++
 rtl/stream_demux_serializer.sv | 202 ++++++++++++++++++++
 tb/tb_stream_demux_serializer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_serializer_pkg.sv
// Shared definitions for the stream demultiplexer / NFA serializer.
// Holds the FSM state encoding, the packet-type codes carried on s_axis_ttype,
// and helpers that derive the serializer geometry from the width parameters.
package stream_demux_serializer_pkg;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StNfaSer    = 2'd1,
      StQueryPass = 2'd2
   } state_e;

   localparam logic TYPE_NFA   = 1'b0;
   localparam logic TYPE_QUERY = 1'b1;

   // Number of NFA words carried by one input beat.
   function automatic int unsigned words_per_beat(input int unsigned data_w,
                                                  input int unsigned nfa_w);
      return data_w / nfa_w;
   endfunction

   // Width of an index that addresses n items; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_demux_serializer_if.sv
// Bus bundle for stream_demux_serializer.
// Carries the input AXI-Stream (with packet type), the NFA word output stream,
// the query beat output stream, the done pulses and the status counters.
// Modports:
//   slave  - view of the demux/serializer block itself
//   master - view of the environment that feeds and drains the block
interface stream_demux_serializer_if #(
   parameter int unsigned C_DATA_WIDTH = 512,
   parameter int unsigned C_NFA_WIDTH  = 64,
   parameter int unsigned C_CNT_WIDTH  = 32
);

   logic                    s_axis_tvalid;
   logic                    s_axis_tready;
   logic [C_DATA_WIDTH-1:0] s_axis_tdata;
   logic                    s_axis_tlast;
   logic                    s_axis_ttype;

   logic                    m_nfa_tvalid;
   logic                    m_nfa_tready;
   logic [C_NFA_WIDTH-1:0]  m_nfa_tdata;
   logic                    m_nfa_tlast;

   logic                    m_query_tvalid;
   logic                    m_query_tready;
   logic [C_DATA_WIDTH-1:0] m_query_tdata;
   logic                    m_query_tlast;

   logic                    nfa_done;
   logic                    query_done;
   logic [C_CNT_WIDTH-1:0]  nfa_word_count;
   logic [C_CNT_WIDTH-1:0]  query_beat_count;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_ttype,
      input  m_nfa_tready, m_query_tready,
      output s_axis_tready,
      output m_nfa_tvalid, m_nfa_tdata, m_nfa_tlast,
      output m_query_tvalid, m_query_tdata, m_query_tlast,
      output nfa_done, query_done, nfa_word_count, query_beat_count
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_ttype,
      output m_nfa_tready, m_query_tready,
      input  s_axis_tready,
      input  m_nfa_tvalid, m_nfa_tdata, m_nfa_tlast,
      input  m_query_tvalid, m_query_tdata, m_query_tlast,
      input  nfa_done, query_done, nfa_word_count, query_beat_count
   );

endinterface

// File: rtl/stream_demux_serializer_axis_reg_slice.sv
// axis_reg_slice: reusable single-stage AXI-Stream register slice.
// One cycle of latency, full throughput under continuous downstream ready.
// Output data/last are held stable while m_valid_o=1 and m_ready_i=0.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   s_valid_i/s_ready_o   upstream handshake, s_data_i/s_last_i payload
//   m_valid_o/m_ready_i   downstream handshake, m_data_o/m_last_o payload
module axis_reg_slice #(
   parameter int unsigned Width = 512
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [Width-1:0] s_data_i,
   input  logic             s_last_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [Width-1:0] m_data_o,
   output logic             m_last_o
);

   logic             valid_q, valid_d;
   logic [Width-1:0] data_q, data_d;
   logic             last_q, last_d;

   // The stage can take a new beat when empty or when it empties this cycle.
   assign s_ready_o = ~valid_q | m_ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (s_ready_o) begin
         valid_d = s_valid_i;
         if (s_valid_i) begin
            data_d = s_data_i;
            last_d = s_last_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign m_valid_o = valid_q;
   assign m_data_o  = data_q;
   assign m_last_o  = last_q;

endmodule

// File: rtl/stream_demux_serializer.sv
// stream_demux_serializer: routes input packets by their first-beat type.
// NFA packets (ttype=0) are serialized into C_DATA_WIDTH/C_NFA_WIDTH words,
// least-significant word first. Query packets (ttype=1) pass through a
// one-stage register slice. Done pulses are registered (one cycle after the
// last output handshake); counters report words/beats of the current packet.
// Ports:
//   data_clk     sole clock
//   data_rst_n   asynchronous active-low reset
//   bus_io       input stream, NFA and query output streams, status
module stream_demux_serializer
   import stream_demux_serializer_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH = 512,
   parameter int unsigned C_NFA_WIDTH  = 64,
   parameter int unsigned C_CNT_WIDTH  = 32
) (
   input  logic                      data_clk,
   input  logic                      data_rst_n,
   stream_demux_serializer_if.slave  bus_io
);

   localparam int unsigned Words = words_per_beat(C_DATA_WIDTH, C_NFA_WIDTH);
   localparam int unsigned IdxW  = idx_width(Words);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

   state_e                  state_q, state_d;
   logic [C_DATA_WIDTH-1:0] beat_q, beat_d;
   logic                    beat_last_q, beat_last_d;
   logic                    beat_vld_q, beat_vld_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic                    qry_last_in_q, qry_last_in_d;
   logic                    nfa_done_q, nfa_done_d;
   logic                    query_done_q, query_done_d;
   logic [C_CNT_WIDTH-1:0]  nfa_cnt_q, nfa_cnt_d;
   logic [C_CNT_WIDTH-1:0]  qry_cnt_q, qry_cnt_d;
   // Low while in reset and for the first edge after release, so the input
   // never reports ready while the block is held in reset.
   logic                    run_q;

   logic                    s_ready;
   logic                    nfa_valid;
   logic                    nfa_hs;
   logic                    nfa_final;
   logic                    qry_out_hs;

   logic                    sl_s_valid;
   logic                    sl_s_ready;
   logic                    sl_m_valid;
   logic [C_DATA_WIDTH-1:0] sl_m_data;
   logic                    sl_m_last;

   logic [Words-1:0][C_NFA_WIDTH-1:0] beat_words;

   assign beat_words = beat_q;
   assign nfa_valid  = (state_q == StNfaSer) & beat_vld_q;
   assign nfa_hs     = nfa_valid & bus_io.m_nfa_tready;
   assign nfa_final  = (idx_q == LastIdx);
   assign qry_out_hs = sl_m_valid & bus_io.m_query_tready;

   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      beat_last_d   = beat_last_q;
      beat_vld_d    = beat_vld_q;
      idx_d         = idx_q;
      qry_last_in_d = qry_last_in_q;
      nfa_cnt_d     = nfa_cnt_q;
      qry_cnt_d     = qry_cnt_q;
      nfa_done_d    = 1'b0;
      query_done_d  = 1'b0;
      s_ready       = 1'b0;
      sl_s_valid    = 1'b0;

      unique case (state_q)
         StIdle: begin
            s_ready = run_q;
            if (run_q && bus_io.s_axis_tvalid) begin
               // Packet type is decided here only; later beats follow this path.
               if (bus_io.s_axis_ttype == TYPE_QUERY) begin
                  sl_s_valid    = 1'b1;
                  qry_last_in_d = bus_io.s_axis_tlast;
                  qry_cnt_d     = '0;
                  state_d       = StQueryPass;
               end else begin
                  beat_d      = bus_io.s_axis_tdata;
                  beat_last_d = bus_io.s_axis_tlast;
                  beat_vld_d  = 1'b1;
                  idx_d       = '0;
                  nfa_cnt_d   = '0;
                  state_d     = StNfaSer;
               end
            end
         end

         StNfaSer: begin
            if (nfa_hs) begin
               nfa_cnt_d = nfa_cnt_q + C_CNT_WIDTH'(1);
               if (!nfa_final) begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
            // Refill mid-packet when the held beat is drained or its final word
            // leaves this cycle; loading in that same cycle avoids a bubble.
            if (!beat_last_q && (!beat_vld_q || (nfa_hs && nfa_final))) begin
               s_ready = 1'b1;
               idx_d   = '0;
               if (bus_io.s_axis_tvalid) begin
                  beat_d      = bus_io.s_axis_tdata;
                  beat_last_d = bus_io.s_axis_tlast;
                  beat_vld_d  = 1'b1;
               end else begin
                  beat_vld_d  = 1'b0;
               end
            end
            if (nfa_hs && nfa_final && beat_last_q) begin
               nfa_done_d = 1'b1;
               beat_vld_d = 1'b0;
               idx_d      = '0;
               state_d    = StIdle;
            end
         end

         StQueryPass: begin
            // Once the last input beat is in the slice, stop accepting so the
            // next packet is typed from IDLE rather than swallowed here.
            s_ready    = ~qry_last_in_q & sl_s_ready;
            sl_s_valid = bus_io.s_axis_tvalid & s_ready;
            if (sl_s_valid && bus_io.s_axis_tlast) begin
               qry_last_in_d = 1'b1;
            end
            if (qry_out_hs) begin
               qry_cnt_d = qry_cnt_q + C_CNT_WIDTH'(1);
               if (sl_m_last) begin
                  query_done_d  = 1'b1;
                  qry_last_in_d = 1'b0;
                  state_d       = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge data_clk or negedge data_rst_n) begin
      if (!data_rst_n) begin
         state_q       <= StIdle;
         beat_q        <= '0;
         beat_last_q   <= 1'b0;
         beat_vld_q    <= 1'b0;
         idx_q         <= '0;
         qry_last_in_q <= 1'b0;
         nfa_done_q    <= 1'b0;
         query_done_q  <= 1'b0;
         nfa_cnt_q     <= '0;
         qry_cnt_q     <= '0;
         run_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         beat_last_q   <= beat_last_d;
         beat_vld_q    <= beat_vld_d;
         idx_q         <= idx_d;
         qry_last_in_q <= qry_last_in_d;
         nfa_done_q    <= nfa_done_d;
         query_done_q  <= query_done_d;
         nfa_cnt_q     <= nfa_cnt_d;
         qry_cnt_q     <= qry_cnt_d;
         run_q         <= 1'b1;
      end
   end

   axis_reg_slice #(
      .Width (C_DATA_WIDTH)
   ) u_query_slice (
      .clk_i     (data_clk),
      .rst_ni    (data_rst_n),
      .s_valid_i (sl_s_valid),
      .s_ready_o (sl_s_ready),
      .s_data_i  (bus_io.s_axis_tdata),
      .s_last_i  (bus_io.s_axis_tlast),
      .m_valid_o (sl_m_valid),
      .m_ready_i (bus_io.m_query_tready),
      .m_data_o  (sl_m_data),
      .m_last_o  (sl_m_last)
   );

   assign bus_io.s_axis_tready    = s_ready;
   assign bus_io.m_nfa_tvalid     = nfa_valid;
   assign bus_io.m_nfa_tdata      = beat_words[idx_q];
   assign bus_io.m_nfa_tlast      = nfa_valid & nfa_final & beat_last_q;
   assign bus_io.m_query_tvalid   = sl_m_valid;
   assign bus_io.m_query_tdata    = sl_m_data;
   assign bus_io.m_query_tlast    = sl_m_last;
   assign bus_io.nfa_done         = nfa_done_q;
   assign bus_io.query_done       = query_done_q;
   assign bus_io.nfa_word_count   = nfa_cnt_q;
   assign bus_io.query_beat_count = qry_cnt_q;

endmodule

// File: tb/tb_stream_demux_serializer.sv
// Directed bench for stream_demux_serializer: reset values, NFA serialization,
// query pass-through, type-flip immunity, random backpressure, mid-packet reset.
module tb_stream_demux_serializer;

   localparam int unsigned DW  = 512;
   localparam int unsigned NW  = 64;
   localparam int unsigned CW  = 32;
   localparam int unsigned WPB = DW / NW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   bit          rand_rdy = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stream_demux_serializer_if #(
      .C_DATA_WIDTH (DW),
      .C_NFA_WIDTH  (NW),
      .C_CNT_WIDTH  (CW)
   ) bus ();

   stream_demux_serializer #(
      .C_DATA_WIDTH (DW),
      .C_NFA_WIDTH  (NW),
      .C_CNT_WIDTH  (CW)
   ) dut (
      .data_clk   (clk),
      .data_rst_n (rst_n),
      .bus_io     (bus)
   );

   // Observed and expected streams.
   logic [NW-1:0] nfa_data_q[$];
   logic          nfa_last_q[$];
   int unsigned   nfa_cyc_q[$];
   logic [DW-1:0] qry_data_q[$];
   logic          qry_last_q[$];
   int unsigned   qry_cyc_q[$];
   int unsigned   in_cyc_q[$];
   logic [NW-1:0] exp_nw[$];
   logic          exp_nl[$];
   logic [DW-1:0] exp_qd[$];
   logic          exp_ql[$];

   int unsigned   nfa_done_cnt = 0;
   int unsigned   qry_done_cnt = 0;
   int unsigned   both_err = 0;
   int unsigned   stab_err = 0;
   logic          pv_n = 1'b0, pr_n = 1'b0, pl_n = 1'b0;
   logic [NW-1:0] pd_n = '0;
   logic          pv_q = 1'b0, pr_q = 1'b0, pl_q = 1'b0;
   logic [DW-1:0] pd_q = '0;

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Sampling monitor, half a cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         pv_n <= 1'b0;
         pv_q <= 1'b0;
      end else begin
         if (bus.m_nfa_tvalid && bus.m_nfa_tready) begin
            nfa_data_q.push_back(bus.m_nfa_tdata);
            nfa_last_q.push_back(bus.m_nfa_tlast);
            nfa_cyc_q.push_back(cyc);
         end
         if (bus.m_query_tvalid && bus.m_query_tready) begin
            qry_data_q.push_back(bus.m_query_tdata);
            qry_last_q.push_back(bus.m_query_tlast);
            qry_cyc_q.push_back(cyc);
         end
         if (bus.s_axis_tvalid && bus.s_axis_tready) in_cyc_q.push_back(cyc);
         if (bus.nfa_done) nfa_done_cnt <= nfa_done_cnt + 1;
         if (bus.query_done) qry_done_cnt <= qry_done_cnt + 1;
         if (bus.m_nfa_tvalid && bus.m_query_tvalid) both_err <= both_err + 1;
         if (pv_n && !pr_n && (!bus.m_nfa_tvalid || bus.m_nfa_tdata !== pd_n ||
                               bus.m_nfa_tlast !== pl_n))
            stab_err <= stab_err + 1;
         if (pv_q && !pr_q && (!bus.m_query_tvalid || bus.m_query_tdata !== pd_q ||
                               bus.m_query_tlast !== pl_q))
            stab_err <= stab_err + 1;
         pv_n <= bus.m_nfa_tvalid;
         pr_n <= bus.m_nfa_tready;
         pd_n <= bus.m_nfa_tdata;
         pl_n <= bus.m_nfa_tlast;
         pv_q <= bus.m_query_tvalid;
         pr_q <= bus.m_query_tready;
         pd_q <= bus.m_query_tdata;
         pl_q <= bus.m_query_tlast;
      end
   end

   // Output ready driver: always 1 unless random backpressure is enabled.
   initial begin
      bus.m_nfa_tready   = 1'b1;
      bus.m_query_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) begin
            bus.m_nfa_tready   = 1'($urandom_range(1, 0));
            bus.m_query_tready = 1'($urandom_range(1, 0));
         end else begin
            bus.m_nfa_tready   = 1'b1;
            bus.m_query_tready = 1'b1;
         end
      end
   end

   // Byte k of the beat is base+k+1, so pat(0) starts 0x..0807060504030201.
   function automatic logic [DW-1:0] pat(input int unsigned base);
      logic [DW-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < DW / 8; k++) r[8*k +: 8] = 8'(base + k + 1);
      return r;
   endfunction

   task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic t,
                            input int unsigned gap);
      int unsigned budget;
      budget = 0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = d;
      bus.s_axis_tlast  = l;
      bus.s_axis_ttype  = t;
      @(negedge clk);
      while (!bus.s_axis_tready && budget < 500) begin
         budget++;
         @(negedge clk);
      end
      if (!bus.s_axis_tready) check_eq("send_ready_timeout", DW'(bus.s_axis_tready), DW'(1));
      @(posedge clk);
      #1;
      bus.s_axis_tvalid = 1'b0;
   endtask

   task automatic send_nfa_pkt(input int unsigned n, input int unsigned base, input bit rnd,
                               input bit flip);
      logic [DW-1:0] b;
      for (int unsigned i = 0; i < n; i++) begin
         b = pat(base + 64 * i);
         send_beat(b, (i == n - 1), (flip && i > 0), rnd ? $urandom_range(2, 0) : 32'd0);
         for (int unsigned j = 0; j < WPB; j++) begin
            exp_nw.push_back(b[j*NW +: NW]);
            exp_nl.push_back((i == n - 1) && (j == WPB - 1));
         end
      end
   endtask

   task automatic send_query_pkt(input int unsigned n, input int unsigned base, input bit rnd);
      logic [DW-1:0] b;
      for (int unsigned i = 0; i < n; i++) begin
         b = pat(base + 64 * i);
         // ttype drops to 0 on later beats; only the first beat's type counts.
         send_beat(b, (i == n - 1), (i == 0), rnd ? $urandom_range(2, 0) : 32'd0);
         exp_qd.push_back(b);
         exp_ql.push_back(i == n - 1);
      end
   endtask

   task automatic drain(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_test();
      nfa_data_q.delete(); nfa_last_q.delete(); nfa_cyc_q.delete();
      qry_data_q.delete(); qry_last_q.delete(); qry_cyc_q.delete();
      in_cyc_q.delete();
      exp_nw.delete(); exp_nl.delete(); exp_qd.delete(); exp_ql.delete();
   endtask

   task automatic compare_streams(input string tag);
      check_eq({tag, "_nfa_n"}, DW'(nfa_data_q.size()), DW'(exp_nw.size()));
      for (int i = 0; i < exp_nw.size() && i < nfa_data_q.size(); i++) begin
         check_eq($sformatf("%s_nw%0d", tag, i), DW'(nfa_data_q[i]), DW'(exp_nw[i]));
         check_eq($sformatf("%s_nl%0d", tag, i), DW'(nfa_last_q[i]), DW'(exp_nl[i]));
      end
      check_eq({tag, "_qry_n"}, DW'(qry_data_q.size()), DW'(exp_qd.size()));
      for (int i = 0; i < exp_qd.size() && i < qry_data_q.size(); i++) begin
         check_eq($sformatf("%s_qd%0d", tag, i), qry_data_q[i], exp_qd[i]);
         check_eq($sformatf("%s_ql%0d", tag, i), DW'(qry_last_q[i]), DW'(exp_ql[i]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_s_tready"}, DW'(bus.s_axis_tready), DW'(0));
      check_eq({tag, "_nfa_tvalid"}, DW'(bus.m_nfa_tvalid), DW'(0));
      check_eq({tag, "_nfa_tlast"}, DW'(bus.m_nfa_tlast), DW'(0));
      check_eq({tag, "_nfa_tdata"}, DW'(bus.m_nfa_tdata), DW'(0));
      check_eq({tag, "_qry_tvalid"}, DW'(bus.m_query_tvalid), DW'(0));
      check_eq({tag, "_qry_tlast"}, DW'(bus.m_query_tlast), DW'(0));
      check_eq({tag, "_qry_tdata"}, bus.m_query_tdata, DW'(0));
      check_eq({tag, "_nfa_done"}, DW'(bus.nfa_done), DW'(0));
      check_eq({tag, "_qry_done"}, DW'(bus.query_done), DW'(0));
      check_eq({tag, "_nfa_cnt"}, DW'(bus.nfa_word_count), DW'(0));
      check_eq({tag, "_qry_cnt"}, DW'(bus.query_beat_count), DW'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned nd0, qd0, budget;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_ttype  = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_release_ready", DW'(bus.s_axis_tready), DW'(1));
      @(posedge clk);
      #1;

      // Two-beat NFA packet, ready always 1.
      start_test();
      nd0 = nfa_done_cnt;
      send_nfa_pkt(2, 0, 1'b0, 1'b0);
      drain(30);
      compare_streams("nfa2");
      check_eq("nfa2_done", DW'(nfa_done_cnt - nd0), DW'(1));
      check_eq("nfa2_count", DW'(bus.nfa_word_count), DW'(16));
      if (nfa_cyc_q.size() == 16 && in_cyc_q.size() == 2) begin
         check_eq("nfa2_first_lat", DW'(nfa_cyc_q[0] - in_cyc_q[0]), DW'(1));
         check_eq("nfa2_no_bubble", DW'(nfa_cyc_q[15] - nfa_cyc_q[0]), DW'(15));
      end

      // Four-beat query packet, ready always 1.
      start_test();
      qd0 = qry_done_cnt;
      send_query_pkt(4, 1000, 1'b0);
      drain(10);
      compare_streams("qry4");
      check_eq("qry4_done", DW'(qry_done_cnt - qd0), DW'(1));
      check_eq("qry4_count", DW'(bus.query_beat_count), DW'(4));
      if (qry_cyc_q.size() == 4 && in_cyc_q.size() == 4) begin
         check_eq("qry4_lat", DW'(qry_cyc_q[0] - in_cyc_q[0]), DW'(1));
         check_eq("qry4_no_gap", DW'(qry_cyc_q[3] - qry_cyc_q[0]), DW'(3));
         check_eq("qry4_in_no_gap", DW'(in_cyc_q[3] - in_cyc_q[0]), DW'(3));
      end

      // NFA with ttype flipping on beat 2, then a query packet.
      start_test();
      nd0 = nfa_done_cnt;
      qd0 = qry_done_cnt;
      send_nfa_pkt(2, 300, 1'b0, 1'b1);
      send_query_pkt(2, 2000, 1'b0);
      drain(20);
      compare_streams("flip");
      check_eq("flip_nfa_done", DW'(nfa_done_cnt - nd0), DW'(1));
      check_eq("flip_qry_done", DW'(qry_done_cnt - qd0), DW'(1));
      check_eq("flip_qry_count", DW'(bus.query_beat_count), DW'(2));

      // Single-beat NFA packet.
      start_test();
      send_nfa_pkt(1, 77, 1'b0, 1'b0);
      drain(20);
      compare_streams("nfa1");
      check_eq("nfa1_count", DW'(bus.nfa_word_count), DW'(8));

      // Random backpressure and random input gaps.
      start_test();
      nd0 = nfa_done_cnt;
      qd0 = qry_done_cnt;
      rand_rdy = 1'b1;
      send_nfa_pkt(3, 500, 1'b1, 1'b0);
      send_query_pkt(3, 3000, 1'b1);
      send_nfa_pkt(1, 900, 1'b1, 1'b1);
      send_query_pkt(1, 4000, 1'b1);
      drain(300);
      rand_rdy = 1'b0;
      drain(2);
      compare_streams("rnd");
      check_eq("rnd_nfa_done", DW'(nfa_done_cnt - nd0), DW'(2));
      check_eq("rnd_qry_done", DW'(qry_done_cnt - qd0), DW'(2));
      check_eq("rnd_qry_count", DW'(bus.query_beat_count), DW'(1));

      // Reset after three words of a single-beat NFA packet.
      start_test();
      send_beat(pat(123), 1'b1, 1'b0, 0);
      budget = 0;
      while (nfa_data_q.size() < 3 && budget < 100) begin
         budget++;
         @(posedge clk);
         #1;
      end
      check_eq("mid_rst_words_seen", DW'(nfa_data_q.size()), DW'(3));
      check_eq("mid_rst_cnt_before", DW'(bus.nfa_word_count), DW'(3));
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_test();
      qd0 = qry_done_cnt;
      send_query_pkt(1, 5000, 1'b0);
      drain(20);
      compare_streams("post_rst");
      check_eq("post_rst_qry_done", DW'(qry_done_cnt - qd0), DW'(1));
      check_eq("post_rst_qry_count", DW'(bus.query_beat_count), DW'(1));

      check_eq("never_both_valid", DW'(both_err), DW'(0));
      check_eq("stable_under_bp", DW'(stab_err), DW'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
